alu_ctr: RTL and testbench

ALU control decoder for the single-cycle/pipelined MIPS datapath. It combines the 2-bit `ALUOp` from the main control unit with the 6-bit R-type `funct` field and produces the 4-bit operation select `ALUctr` for the ALU. The outputs are registered, so the decision is available one clock after the inputs are presented. It also flags function codes it does not recognise.

---
 rtl/alu_ctr_if.sv | 27 ++
 rtl/alu_ctr.sv | 95 +++++++++
 tb/tb_alu_ctr.sv | 173 +++++++++++++++++
 3 files changed

// File: rtl/alu_ctr_if.sv
// alu_ctr_if: bundles the ALU control decoder signals.
//   ALUOp   - operation class from the main control unit (00 ld/st, 01 branch, 10 R-type, 11 rsvd)
//   funct   - R-type function field, instruction bits [5:0]
//   ALUctr  - registered ALU operation select
//   illegal - registered flag, set when the ALUOp/funct combination is not decodable
// master: control side that drives ALUOp/funct and consumes the decode.
// slave:  the decoder itself.
interface alu_ctr_if;
  logic [1:0] ALUOp;
  logic [5:0] funct;
  logic [3:0] ALUctr;
  logic       illegal;

  modport master (
    output ALUOp,
    output funct,
    input  ALUctr,
    input  illegal
  );

  modport slave (
    input  ALUOp,
    input  funct,
    output ALUctr,
    output illegal
  );
endinterface

// File: rtl/alu_ctr.sv
// alu_ctr: ALU control decoder for the MIPS datapath.
// Combines the 2-bit ALUOp class with the 6-bit R-type funct field and produces a registered
// 4-bit ALU operation select plus an illegal-combination flag, one clock after the inputs.
// Ports:
//   clk   - clock, rising edge
//   rst_n - synchronous active-low reset; outputs go to ALUctr=0000, illegal=0
//   bus   - alu_ctr_if.slave: ALUOp, funct in; ALUctr, illegal out
// Build option: define ALU_CTR_EXT_EN to also accept addu/subu/xor/sltu under ALUOp=10.
module alu_ctr (
  input  logic         clk,
  input  logic         rst_n,
  alu_ctr_if.slave     bus
);

  // ALU operation encodings
  localparam logic [3:0] OpAnd  = 4'b0000;
  localparam logic [3:0] OpOr   = 4'b0001;
  localparam logic [3:0] OpAdd  = 4'b0010;
  localparam logic [3:0] OpSub  = 4'b0110;
  localparam logic [3:0] OpSlt  = 4'b0111;
  localparam logic [3:0] OpNor  = 4'b1100;
`ifdef ALU_CTR_EXT_EN
  localparam logic [3:0] OpXor  = 4'b1101;
  localparam logic [3:0] OpSltu = 4'b1000;
`endif

  // R-type function codes
  localparam logic [5:0] FnAdd  = 6'b100000;
  localparam logic [5:0] FnSub  = 6'b100010;
  localparam logic [5:0] FnAnd  = 6'b100100;
  localparam logic [5:0] FnOr   = 6'b100101;
  localparam logic [5:0] FnNor  = 6'b100111;
  localparam logic [5:0] FnSlt  = 6'b101010;
`ifdef ALU_CTR_EXT_EN
  localparam logic [5:0] FnAddu = 6'b100001;
  localparam logic [5:0] FnSubu = 6'b100011;
  localparam logic [5:0] FnXor  = 6'b100110;
  localparam logic [5:0] FnSltu = 6'b101011;
`endif

  logic [3:0] ctr_d, ctr_q;
  logic       illegal_d, illegal_q;

  // Undecodable combinations fall back to ADD so the ALU still sees a benign operation.
  always_comb begin
    ctr_d     = OpAdd;
    illegal_d = 1'b0;
    unique case (bus.ALUOp)
      2'b00: ctr_d = OpAdd;
      2'b01: ctr_d = OpSub;
      2'b10: begin
        case (bus.funct)
          FnAdd:   ctr_d = OpAdd;
          FnSub:   ctr_d = OpSub;
          FnAnd:   ctr_d = OpAnd;
          FnOr:    ctr_d = OpOr;
          FnNor:   ctr_d = OpNor;
          FnSlt:   ctr_d = OpSlt;
`ifdef ALU_CTR_EXT_EN
          FnAddu:  ctr_d = OpAdd;
          FnSubu:  ctr_d = OpSub;
          FnXor:   ctr_d = OpXor;
          FnSltu:  ctr_d = OpSltu;
`endif
          default: begin
            ctr_d     = OpAdd;
            illegal_d = 1'b1;
          end
        endcase
      end
      2'b11: begin
        ctr_d     = OpAdd;
        illegal_d = 1'b1;
      end
      default: begin
        ctr_d     = OpAdd;
        illegal_d = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ctr_q     <= 4'b0000;
      illegal_q <= 1'b0;
    end else begin
      ctr_q     <= ctr_d;
      illegal_q <= illegal_d;
    end
  end

  assign bus.ALUctr  = ctr_q;
  assign bus.illegal = illegal_q;

endmodule

// File: tb/tb_alu_ctr.sv
module tb_alu_ctr;

  logic clk;
  logic rst_n;
  int   tests;
  int   fails;

  alu_ctr_if bus ();

  alu_ctr dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Inputs are driven just after a falling edge, captured at the next rising edge,
  // and observed at the following falling edge.
  task automatic drive(input logic [1:0] op, input logic [5:0] fn);
    bus.ALUOp = op;
    bus.funct = fn;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    drive(2'b10, 6'b100000);
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      tests++;
      if (bus.ALUctr !== 4'b0000 || bus.illegal !== 1'b0) begin
        fails++;
        $display("FAIL reset_hold%0d: ALUctr=%b illegal=%b, expected ALUctr=0000 illegal=0",
                 i, bus.ALUctr, bus.illegal);
      end
    end
    rst_n = 1'b1;
    @(negedge clk);
    tests++;
    if (bus.ALUctr !== 4'b0010 || bus.illegal !== 1'b0) begin
      fails++;
      $display("FAIL reset_release: ALUctr=%b illegal=%b, expected ALUctr=0010 illegal=0",
               bus.ALUctr, bus.illegal);
    end
  endtask

  // Reset must wait for a clock edge and must beat the decode.
  task automatic test_sync_reset();
    drive(2'b11, 6'b000000);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    tests++;
    if (bus.ALUctr !== 4'b0010 || bus.illegal !== 1'b1) begin
      fails++;
      $display("FAIL reset_not_async: ALUctr=%b illegal=%b, expected ALUctr=0010 illegal=1",
               bus.ALUctr, bus.illegal);
    end
    @(negedge clk);
    tests++;
    if (bus.ALUctr !== 4'b0000 || bus.illegal !== 1'b0) begin
      fails++;
      $display("FAIL reset_priority: ALUctr=%b illegal=%b, expected ALUctr=0000 illegal=0",
               bus.ALUctr, bus.illegal);
    end
    rst_n = 1'b1;
  endtask

  task automatic test_class_decode();
    logic [1:0] ops [4] = '{2'b00, 2'b01, 2'b00, 2'b01};
    logic [5:0] fns [4] = '{6'b000000, 6'b000000, 6'b100100, 6'b111111};
    logic [3:0] exp [4] = '{4'b0010, 4'b0110, 4'b0010, 4'b0110};
    for (int i = 0; i < 4; i++) begin
      drive(ops[i], fns[i]);
      @(negedge clk);
      tests++;
      if (bus.ALUctr !== exp[i] || bus.illegal !== 1'b0) begin
        fails++;
        $display("FAIL class%0d op=%b fn=%b: ALUctr=%b illegal=%b, expected ALUctr=%b illegal=0",
                 i, ops[i], fns[i], bus.ALUctr, bus.illegal, exp[i]);
      end
    end
  endtask

  task automatic test_rtype_sweep();
    logic [5:0] fns [6] = '{6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b100111, 6'b101010};
    logic [3:0] exp [6] = '{4'b0010, 4'b0110, 4'b0000, 4'b0001, 4'b1100, 4'b0111};
    for (int i = 0; i < 6; i++) begin
      drive(2'b10, fns[i]);
      @(negedge clk);
      tests++;
      if (bus.ALUctr !== exp[i] || bus.illegal !== 1'b0) begin
        fails++;
        $display("FAIL rtype fn=%b: ALUctr=%b illegal=%b, expected ALUctr=%b illegal=0",
                 fns[i], bus.ALUctr, bus.illegal, exp[i]);
      end
    end
  endtask

  task automatic test_illegal();
    logic [1:0] ops [4] = '{2'b10, 2'b11, 2'b10, 2'b11};
    logic [5:0] fns [4] = '{6'b000000, 6'b100000, 6'b111111, 6'b000000};
    for (int i = 0; i < 4; i++) begin
      drive(ops[i], fns[i]);
      @(negedge clk);
      tests++;
      if (bus.ALUctr !== 4'b0010 || bus.illegal !== 1'b1) begin
        fails++;
        $display("FAIL illegal%0d op=%b fn=%b: ALUctr=%b illegal=%b, expected ALUctr=0010 illegal=1",
                 i, ops[i], fns[i], bus.ALUctr, bus.illegal);
      end
    end
  endtask

  task automatic test_extension();
    logic [5:0] fns [4] = '{6'b100001, 6'b100011, 6'b100110, 6'b101011};
`ifdef ALU_CTR_EXT_EN
    logic [3:0] exp [4] = '{4'b0010, 4'b0110, 4'b1101, 4'b1000};
    logic       exp_ill = 1'b0;
`else
    logic [3:0] exp [4] = '{4'b0010, 4'b0010, 4'b0010, 4'b0010};
    logic       exp_ill = 1'b1;
`endif
    for (int i = 0; i < 4; i++) begin
      drive(2'b10, fns[i]);
      @(negedge clk);
      tests++;
      if (bus.ALUctr !== exp[i] || bus.illegal !== exp_ill) begin
        fails++;
        $display("FAIL ext fn=%b: ALUctr=%b illegal=%b, expected ALUctr=%b illegal=%b",
                 fns[i], bus.ALUctr, bus.illegal, exp[i], exp_ill);
      end
    end
  endtask

  // New inputs every cycle; each observation must match the inputs from one cycle earlier.
  task automatic test_back_to_back();
    logic [1:0] ops [5] = '{2'b00, 2'b10, 2'b10, 2'b11, 2'b01};
    logic [5:0] fns [5] = '{6'b010101, 6'b100000, 6'b101010, 6'b100000, 6'b000000};
    logic [3:0] exp [5] = '{4'b0010, 4'b0010, 4'b0111, 4'b0010, 4'b0110};
    logic       ill [5] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    for (int i = 0; i < 5; i++) begin
      drive(ops[i], fns[i]);
      @(negedge clk);
      tests++;
      if (bus.ALUctr !== exp[i] || bus.illegal !== ill[i]) begin
        fails++;
        $display("FAIL stream%0d: ALUctr=%b illegal=%b, expected ALUctr=%b illegal=%b",
                 i, bus.ALUctr, bus.illegal, exp[i], ill[i]);
      end
    end
  endtask

  initial begin
    tests = 0;
    fails = 0;
    rst_n = 1'b0;
    drive(2'b00, 6'b000000);
    @(negedge clk);
    test_reset();
    test_class_decode();
    test_rtype_sweep();
    test_illegal();
    test_extension();
    test_back_to_back();
    test_sync_reset();
    @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
